// File: rtl/ctrl_sequencer_pkg.sv
// Shared be8 control definitions: opcodes, T-state numbers and the control-word layout.
// The opcode values also appear in the IR, in the assembler tests and in the bench.
package ctrl_sequencer_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam int unsigned T0 = 0;
   localparam int unsigned T1 = 1;
   localparam int unsigned T2 = 2;
   localparam int unsigned T3 = 3;
   localparam int unsigned T4 = 4;

   // j is the PC load request in active-high form; the top level inverts it onto Jn.
   typedef struct packed {
      logic hlt;
      logic mi;
      logic ri;
      logic ro;
      logic ii;
      logic io;
      logic ai;
      logic ao;
      logic bi;
      logic so;
      logic su;
      logic fi;
      logic oi;
      logic co;
      logic ce;
      logic j;
   } cw_t;

   localparam int CW_W = $bits(cw_t);

endpackage

// File: rtl/ctrl_ucode_rom.sv
// Combinational microcode: (opcode, step, flags) -> control word plus the instruction's
// last-active-step mark.
module ctrl_ucode_rom
   import ctrl_sequencer_pkg::*;
#(
   parameter int STEP_W = 3
) (
   input  logic [3:0]        op,
   input  logic [STEP_W-1:0] step,
   input  logic              cf,
   input  logic              zf,
   output cw_t               cw,
   output logic              last
);

   localparam logic [STEP_W-1:0] S0 = STEP_W'(T0);
   localparam logic [STEP_W-1:0] S1 = STEP_W'(T1);
   localparam logic [STEP_W-1:0] S2 = STEP_W'(T2);
   localparam logic [STEP_W-1:0] S3 = STEP_W'(T3);
   localparam logic [STEP_W-1:0] S4 = STEP_W'(T4);

   always_comb begin
      cw   = '0;
      last = 1'b0;
      case (step)
         S0: begin
            cw.co = 1'b1;
            cw.mi = 1'b1;
         end
         S1: begin
            cw.ro = 1'b1;
            cw.ii = 1'b1;
            cw.ce = 1'b1;
         end
         S2: begin
            case (op)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  cw.io = 1'b1;
                  cw.mi = 1'b1;
               end
               OP_LDI: begin
                  cw.io = 1'b1;
                  cw.ai = 1'b1;
                  last  = 1'b1;
               end
               OP_JMP: begin
                  cw.io = 1'b1;
                  cw.j  = 1'b1;
                  last  = 1'b1;
               end
               OP_JC: begin
                  cw.io = cf;
                  cw.j  = cf;
                  last  = 1'b1;
               end
               OP_JZ: begin
                  cw.io = zf;
                  cw.j  = zf;
                  last  = 1'b1;
               end
               OP_OUT: begin
                  cw.ao = 1'b1;
                  cw.oi = 1'b1;
                  last  = 1'b1;
               end
               OP_HLT: begin
                  cw.hlt = 1'b1;
                  last   = 1'b1;
               end
               OP_NOP:  last = 1'b1;
               default: last = 1'b1;
            endcase
         end
         S3: begin
            case (op)
               OP_LDA: begin
                  cw.ro = 1'b1;
                  cw.ai = 1'b1;
                  last  = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  cw.ro = 1'b1;
                  cw.bi = 1'b1;
               end
               OP_STA: begin
                  cw.ao = 1'b1;
                  cw.ri = 1'b1;
                  last  = 1'b1;
               end
               default: last = 1'b1;
            endcase
         end
         S4: begin
            last = 1'b1;
            if (op == OP_ADD || op == OP_SUB) begin
               cw.so = 1'b1;
               cw.ai = 1'b1;
               cw.fi = 1'b1;
               cw.su = (op == OP_SUB);
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ctrl_sequencer.sv
// be8 microcode sequencer: T-state counter, halt latch and gated control-word outputs.
// step | meaning
// 0    | T0 fetch: PC onto bus, MAR load
// 1    | T1 fetch: RAM to IR, PC increment
// 2-4  | T2..T4 execute, decoded from IR_OP and flags
// 5-7  | unreachable; no controls, return to T0
module ctrl_sequencer
   import ctrl_sequencer_pkg::*;
#(
   parameter bit EARLY_END = 1'b1,
   parameter int STEP_W    = 3
) (
   input  logic              CLK,
   input  logic              RESETn,
   input  logic              CLR,
   input  logic [3:0]        IR_OP,
   input  logic              CF,
   input  logic              ZF,
   output logic [STEP_W-1:0] STEP,
   output logic              HALTED,
   output logic              HLT,
   output logic              MI,
   output logic              RI,
   output logic              RO,
   output logic              II,
   output logic              IO,
   output logic              AI,
   output logic              AO,
   output logic              BI,
   output logic              SO,
   output logic              SU,
   output logic              FI,
   output logic              OI,
   output logic              CO,
   output logic              CE,
   output logic              Jn
);

   localparam logic [STEP_W-1:0] S4 = STEP_W'(T4);

   logic [STEP_W-1:0] step_q;
   logic              halted_q;
   cw_t               cw_rom;
   cw_t               cw_g;
   logic              last;
   logic              active;

   ctrl_ucode_rom #(.STEP_W(STEP_W)) u_rom (
      .op   (IR_OP),
      .step (step_q),
      .cf   (CF),
      .zf   (ZF),
      .cw   (cw_rom),
      .last (last)
   );

   // A halting T2 freezes the step where it is; only reset or CLR moves it again.
   always_ff @(posedge CLK) begin
      if (!RESETn || CLR) begin
         step_q   <= '0;
         halted_q <= 1'b0;
      end else if (halted_q) begin
         step_q   <= step_q;
         halted_q <= 1'b1;
      end else if (cw_rom.hlt) begin
         halted_q <= 1'b1;
      end else if (step_q >= S4 || (EARLY_END && last)) begin
         step_q <= '0;
      end else begin
         step_q <= step_q + STEP_W'(1);
      end
   end

   assign active = RESETn & ~halted_q;
   assign cw_g   = active ? cw_rom : '0;

   assign STEP   = step_q;
   assign HALTED = halted_q;
   assign HLT    = cw_g.hlt;
   assign MI     = cw_g.mi;
   assign RI     = cw_g.ri;
   assign RO     = cw_g.ro;
   assign II     = cw_g.ii;
   assign IO     = cw_g.io;
   assign AI     = cw_g.ai;
   assign AO     = cw_g.ao;
   assign BI     = cw_g.bi;
   assign SO     = cw_g.so;
   assign SU     = cw_g.su;
   assign FI     = cw_g.fi;
   assign OI     = cw_g.oi;
   assign CO     = cw_g.co;
   assign CE     = cw_g.ce;
   assign Jn     = ~cw_g.j;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: one EARLY_END=1 instance and one EARLY_END=0 instance
// driven from the same inputs.
module tb_ctrl_sequencer;

   localparam logic [15:0] M_HLT = 16'h8000;
   localparam logic [15:0] M_MI  = 16'h4000;
   localparam logic [15:0] M_RI  = 16'h2000;
   localparam logic [15:0] M_RO  = 16'h1000;
   localparam logic [15:0] M_II  = 16'h0800;
   localparam logic [15:0] M_IO  = 16'h0400;
   localparam logic [15:0] M_AI  = 16'h0200;
   localparam logic [15:0] M_AO  = 16'h0100;
   localparam logic [15:0] M_BI  = 16'h0080;
   localparam logic [15:0] M_SO  = 16'h0040;
   localparam logic [15:0] M_SU  = 16'h0020;
   localparam logic [15:0] M_FI  = 16'h0010;
   localparam logic [15:0] M_OI  = 16'h0008;
   localparam logic [15:0] M_CO  = 16'h0004;
   localparam logic [15:0] M_CE  = 16'h0002;
   localparam logic [15:0] M_J   = 16'h0001;

   logic       CLK;
   logic       RESETn;
   logic       CLR;
   logic [3:0] IR_OP;
   logic       CF;
   logic       ZF;

   logic [2:0] STEP;
   logic HALTED, HLT, MI, RI, RO, II, IO, AI, AO, BI, SO, SU, FI, OI, CO, CE, Jn;
   logic [2:0] z_STEP;
   logic z_HALTED, z_HLT, z_MI, z_RI, z_RO, z_II, z_IO, z_AI, z_AO, z_BI, z_SO, z_SU, z_FI;
   logic z_OI, z_CO, z_CE, z_Jn;

   logic [15:0] cw_obs;
   logic [15:0] z_cw;

   int n_cmp = 0;
   int n_err = 0;

   ctrl_sequencer #(.EARLY_END(1'b1), .STEP_W(3)) dut (
      .CLK(CLK), .RESETn(RESETn), .CLR(CLR), .IR_OP(IR_OP), .CF(CF), .ZF(ZF),
      .STEP(STEP), .HALTED(HALTED), .HLT(HLT), .MI(MI), .RI(RI), .RO(RO), .II(II),
      .IO(IO), .AI(AI), .AO(AO), .BI(BI), .SO(SO), .SU(SU), .FI(FI), .OI(OI),
      .CO(CO), .CE(CE), .Jn(Jn)
   );

   ctrl_sequencer #(.EARLY_END(1'b0), .STEP_W(3)) dut0 (
      .CLK(CLK), .RESETn(RESETn), .CLR(CLR), .IR_OP(IR_OP), .CF(CF), .ZF(ZF),
      .STEP(z_STEP), .HALTED(z_HALTED), .HLT(z_HLT), .MI(z_MI), .RI(z_RI), .RO(z_RO),
      .II(z_II), .IO(z_IO), .AI(z_AI), .AO(z_AO), .BI(z_BI), .SO(z_SO), .SU(z_SU),
      .FI(z_FI), .OI(z_OI), .CO(z_CO), .CE(z_CE), .Jn(z_Jn)
   );

   assign cw_obs = {HLT, MI, RI, RO, II, IO, AI, AO, BI, SO, SU, FI, OI, CO, CE, ~Jn};
   assign z_cw   = {z_HLT, z_MI, z_RI, z_RO, z_II, z_IO, z_AI, z_AO, z_BI, z_SO, z_SU,
                    z_FI, z_OI, z_CO, z_CE, ~z_Jn};

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Leaves the bench at a falling edge with both instances in T0.
   task automatic sync_to_t0();
      @(negedge CLK);
      CLR = 1'b1;
      @(negedge CLK);
      CLR = 1'b0;
   endtask

   task automatic test_reset();
      RESETn = 1'b0; CLR = 1'b0; IR_OP = 4'h0; CF = 1'b0; ZF = 1'b0;
      #1;
      n_cmp++;
      if (cw_obs !== 16'h0000 || Jn !== 1'b1) begin
         n_err++;
         $display("FAIL reset_pre_edge: cw=%h Jn=%b, want cw=0000 Jn=1", cw_obs, Jn);
      end
      @(negedge CLK);
      #1;
      n_cmp++;
      if (cw_obs !== 16'h0000 || STEP !== 3'd0 || HALTED !== 1'b0) begin
         n_err++;
         $display("FAIL reset_held: cw=%h step=%0d halted=%b, want cw=0000 step=0 halted=0",
                  cw_obs, STEP, HALTED);
      end
      @(negedge CLK);
      RESETn = 1'b1;
      #1;
      n_cmp++;
      if (STEP !== 3'd0 || cw_obs !== (M_CO | M_MI)) begin
         n_err++;
         $display("FAIL reset_release: step=%0d cw=%h, want step=0 cw=%h", STEP, cw_obs,
                  M_CO | M_MI);
      end
   endtask

   task automatic test_lda_add();
      logic [3:0]  ops[10]   = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2};
      int          steps[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 0};
      logic [15:0] exp[10]   = '{M_CO | M_MI, M_RO | M_II | M_CE, M_IO | M_MI, M_RO | M_AI,
                                 M_CO | M_MI, M_RO | M_II | M_CE, M_IO | M_MI, M_RO | M_BI,
                                 M_SO | M_AI | M_FI, M_CO | M_MI};
      sync_to_t0();
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge CLK);
         IR_OP = ops[i];
         #1;
         n_cmp++;
         if (STEP !== 3'(steps[i]) || cw_obs !== exp[i]) begin
            n_err++;
            $display("FAIL lda_add[%0d]: step=%0d cw=%h, want step=%0d cw=%h",
                     i, STEP, cw_obs, steps[i], exp[i]);
         end
      end
   endtask

   task automatic test_sub();
      int          steps[6] = '{0, 1, 2, 3, 4, 0};
      logic [15:0] exp[6]   = '{M_CO | M_MI, M_RO | M_II | M_CE, M_IO | M_MI, M_RO | M_BI,
                                M_SO | M_SU | M_AI | M_FI, M_CO | M_MI};
      sync_to_t0();
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge CLK);
         IR_OP = 4'h3;
         #1;
         n_cmp++;
         if (STEP !== 3'(steps[i]) || cw_obs !== exp[i]) begin
            n_err++;
            $display("FAIL sub[%0d]: step=%0d cw=%h, want step=%0d cw=%h",
                     i, STEP, cw_obs, steps[i], exp[i]);
         end
      end
   endtask

   task automatic test_cond_jump();
      logic [3:0]  ops[4] = '{4'h7, 4'h7, 4'h8, 4'h8};
      logic        cfs[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic        zfs[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [15:0] t2[4]  = '{16'h0000, M_IO | M_J, 16'h0000, M_IO | M_J};
      logic [15:0] exp;
      int          steps[4] = '{0, 1, 2, 0};
      for (int k = 0; k < 4; k++) begin
         sync_to_t0();
         for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge CLK);
            IR_OP = ops[k]; CF = cfs[k]; ZF = zfs[k];
            exp = (i == 0 || i == 3) ? (M_CO | M_MI) : (i == 1) ? (M_RO | M_II | M_CE) : t2[k];
            #1;
            n_cmp++;
            if (STEP !== 3'(steps[i]) || cw_obs !== exp) begin
               n_err++;
               $display("FAIL cond_jump[%0d.%0d]: step=%0d cw=%h Jn=%b, want step=%0d cw=%h",
                        k, i, STEP, cw_obs, Jn, steps[i], exp);
            end
         end
      end
      sync_to_t0();
      IR_OP = 4'h7; CF = 1'b0; ZF = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      #1;
      n_cmp++;
      if (STEP !== 3'd2 || Jn !== 1'b1 || IO !== 1'b0) begin
         n_err++;
         $display("FAIL jc_flag_low: step=%0d Jn=%b IO=%b, want step=2 Jn=1 IO=0", STEP, Jn, IO);
      end
      CF = 1'b1;
      #1;
      n_cmp++;
      if (Jn !== 1'b0 || IO !== 1'b1) begin
         n_err++;
         $display("FAIL jc_flag_follow: Jn=%b IO=%b, want Jn=0 IO=1", Jn, IO);
      end
      CF = 1'b0;
   endtask

   task automatic test_hlt();
      logic [15:0] exp[3] = '{M_CO | M_MI, M_RO | M_II | M_CE, M_HLT};
      sync_to_t0();
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge CLK);
         IR_OP = 4'hF;
         #1;
         n_cmp++;
         if (STEP !== 3'(i) || cw_obs !== exp[i] || HALTED !== 1'b0) begin
            n_err++;
            $display("FAIL hlt_run[%0d]: step=%0d cw=%h halted=%b, want step=%0d cw=%h halted=0",
                     i, STEP, cw_obs, HALTED, i, exp[i]);
         end
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         IR_OP = 4'(i);
         CF = i[0];
         ZF = i[1];
         #1;
         n_cmp++;
         if (STEP !== 3'd2 || HALTED !== 1'b1 || cw_obs !== 16'h0000 || Jn !== 1'b1) begin
            n_err++;
            $display("FAIL hlt_hold[%0d]: step=%0d halted=%b cw=%h Jn=%b, want step=2 halted=1 cw=0000 Jn=1",
                     i, STEP, HALTED, cw_obs, Jn);
         end
      end
      @(negedge CLK);
      CLR = 1'b1; IR_OP = 4'h0; CF = 1'b0; ZF = 1'b0;
      #1;
      n_cmp++;
      if (HALTED !== 1'b1 || cw_obs !== 16'h0000) begin
         n_err++;
         $display("FAIL hlt_clr_pending: halted=%b cw=%h, want halted=1 cw=0000", HALTED, cw_obs);
      end
      @(negedge CLK);
      CLR = 1'b0;
      #1;
      n_cmp++;
      if (STEP !== 3'd0 || HALTED !== 1'b0 || cw_obs !== (M_CO | M_MI)) begin
         n_err++;
         $display("FAIL hlt_release: step=%0d halted=%b cw=%h, want step=0 halted=0 cw=%h",
                  STEP, HALTED, cw_obs, M_CO | M_MI);
      end
   endtask

   task automatic test_mid_clr();
      logic [15:0] exp[4] = '{M_CO | M_MI, M_RO | M_II | M_CE, M_IO | M_MI, M_RO | M_BI};
      sync_to_t0();
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge CLK);
         IR_OP = 4'h2;
         if (i == 3) CLR = 1'b1;
         #1;
         n_cmp++;
         if (STEP !== 3'(i) || cw_obs !== exp[i]) begin
            n_err++;
            $display("FAIL mid_clr_run[%0d]: step=%0d cw=%h, want step=%0d cw=%h",
                     i, STEP, cw_obs, i, exp[i]);
         end
      end
      @(negedge CLK);
      CLR = 1'b0;
      IR_OP = 4'h0;
      #1;
      n_cmp++;
      if (STEP !== 3'd0 || cw_obs !== (M_CO | M_MI)) begin
         n_err++;
         $display("FAIL mid_clr_restart: step=%0d cw=%h, want step=0 cw=%h", STEP, cw_obs,
                  M_CO | M_MI);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         #1;
         n_cmp++;
         if ((cw_obs & (M_SO | M_AI | M_FI)) !== 16'h0000) begin
            n_err++;
            $display("FAIL mid_clr_no_pulse[%0d]: cw=%h, want SO/AI/FI clear", i, cw_obs);
         end
      end
   endtask

   task automatic test_no_early_end();
      logic [3:0]  ops[12]   = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1,
                                 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
      int          steps[12] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1};
      logic [15:0] exp[12]   = '{M_CO | M_MI, M_RO | M_II | M_CE, 16'h0000, 16'h0000, 16'h0000,
                                 M_CO | M_MI, M_RO | M_II | M_CE, M_IO | M_MI, M_RO | M_AI,
                                 16'h0000, M_CO | M_MI, M_RO | M_II | M_CE};
      sync_to_t0();
      for (int i = 0; i < 12; i++) begin
         if (i > 0) @(negedge CLK);
         IR_OP = ops[i];
         #1;
         n_cmp++;
         if (z_STEP !== 3'(steps[i]) || z_cw !== exp[i]) begin
            n_err++;
            $display("FAIL no_early_end[%0d]: step=%0d cw=%h, want step=%0d cw=%h",
                     i, z_STEP, z_cw, steps[i], exp[i]);
         end
      end
   endtask

   task automatic test_random_stream();
      int len_tab[16] = '{3, 4, 5, 5, 4, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
      logic [3:0] op;
      logic first = 1'b1;
      sync_to_t0();
      for (int k = 0; k < 40; k++) begin
         op = 4'($urandom_range(0, 14));
         for (int c = 0; c < len_tab[op]; c++) begin
            if (!first) @(negedge CLK);
            first = 1'b0;
            IR_OP = op;
            CF = 1'($urandom_range(0, 1));
            ZF = 1'($urandom_range(0, 1));
            #1;
            n_cmp++;
            if (STEP !== 3'(c)) begin
               n_err++;
               $display("FAIL rand_step[%0d op=%h]: step=%0d, want %0d", k, op, STEP, c);
            end
            n_cmp++;
            if ($countones({CO, RO, IO, AO, SO}) > 1 || (CE === 1'b1 && Jn === 1'b0)) begin
               n_err++;
               $display("FAIL rand_bus_early[%0d]: drivers=%b CE=%b Jn=%b, want <=1 driver and not CE&!Jn",
                        k, {CO, RO, IO, AO, SO}, CE, Jn);
            end
            n_cmp++;
            if ($countones({z_CO, z_RO, z_IO, z_AO, z_SO}) > 1 || (z_CE === 1'b1 && z_Jn === 1'b0)) begin
               n_err++;
               $display("FAIL rand_bus_full[%0d]: drivers=%b CE=%b Jn=%b, want <=1 driver and not CE&!Jn",
                        k, {z_CO, z_RO, z_IO, z_AO, z_SO}, z_CE, z_Jn);
            end
         end
      end
      @(negedge CLK);
      #1;
      n_cmp++;
      if (STEP !== 3'd0) begin
         n_err++;
         $display("FAIL rand_end_step: step=%0d, want 0", STEP);
      end
   endtask

   initial begin
      test_reset();
      test_lda_add();
      test_sub();
      test_cond_jump();
      test_hlt();
      test_mid_clr();
      test_no_early_end();
      test_random_stream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
